// File: rtl/btb_predictor.sv
// btb_predictor: fully-associative branch target buffer with per-entry
// saturating direction counters, round-robin replacement and statistics.
//
// Ports:
//   clk, RST            clock and synchronous active-high reset
//   flush               clears every valid bit (counters/targets/stats kept)
//   pc_in               lookup PC (combinational -> hit/pred_taken/pred_target)
//   upd_*               resolved-branch update from the execute stage
//   mispredict          registered upd_pred != upd_taken of the previous cycle
//   dbg_idx, dbg_*      combinational view of one entry's registered state
//   stat_branches       saturating count of resolved branches
//   stat_mispred        saturating count of mispredicted branches
module btb_predictor #(
    parameter int ENTRIES  = 8,
    parameter int CTR_BITS = 2,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       flush,
    input  logic [31:0]                pc_in,
    output logic                       hit,
    output logic                       pred_taken,
    output logic [31:0]                pred_target,
    input  logic                       upd_valid,
    input  logic [31:0]                upd_pc,
    input  logic [31:0]                upd_target,
    input  logic                       upd_taken,
    input  logic                       upd_pred,
    output logic                       mispredict,
    input  logic [$clog2(ENTRIES)-1:0] dbg_idx,
    output logic                       dbg_valid,
    output logic [31:0]                dbg_tag,
    output logic [31:0]                dbg_target,
    output logic [CTR_BITS-1:0]        dbg_state,
    output logic [CNT_W-1:0]           stat_branches,
    output logic [CNT_W-1:0]           stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [31:0]         tag_q    [ENTRIES];
    logic [31:0]         tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                mispredict_q, mispredict_d;
    logic [CNT_W-1:0]    stat_branches_q, stat_branches_d;
    logic [CNT_W-1:0]    stat_mispred_q, stat_mispred_d;

    logic                lk_hit;
    logic [IDX_W-1:0]    lk_idx;
    logic                upd_hit;
    logic [IDX_W-1:0]    upd_idx;
    logic                has_invalid;
    logic [IDX_W-1:0]    inv_idx;
    logic [IDX_W-1:0]    victim_idx;
    logic                upd_mispred;

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == pc_in)) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        hit         = !RST && lk_hit;
        pred_taken  = hit && ctr_q[lk_idx][CTR_BITS-1];
        pred_target = pred_taken ? target_q[lk_idx] : pc_in + 32'd4;
    end

    always_comb begin
        upd_hit     = 1'b0;
        upd_idx     = '0;
        has_invalid = 1'b0;
        inv_idx     = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == upd_pc)) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
        end
        // Descending scan so the last assignment is the lowest invalid index.
        for (int unsigned i = ENTRIES; i > 0; i--) begin
            if (!valid_q[i-1]) begin
                has_invalid = 1'b1;
                inv_idx     = IDX_W'(i - 1);
            end
        end
        victim_idx = has_invalid ? inv_idx : rr_ptr_q;
    end

    always_comb begin
        valid_d         = valid_q;
        tag_d           = tag_q;
        target_d        = target_q;
        ctr_d           = ctr_q;
        rr_ptr_d        = rr_ptr_q;
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        upd_mispred     = upd_valid && (upd_pred != upd_taken);
        mispredict_d    = upd_mispred;

        if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != '1) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 1'b1;
                    end
                    target_d[upd_idx] = upd_target;
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 1'b1;
                end
            end else if (upd_taken && !flush) begin
                valid_d[victim_idx]  = 1'b1;
                tag_d[victim_idx]    = upd_pc;
                target_d[victim_idx] = upd_target;
                ctr_d[victim_idx]    = CTR_WEAK_TAKEN;
                if (!has_invalid) begin
                    rr_ptr_d = rr_ptr_q + 1'b1;
                end
            end
            if (stat_branches_q != '1) begin
                stat_branches_d = stat_branches_q + 1'b1;
            end
        end

        if (upd_mispred && (stat_mispred_q != '1)) begin
            stat_mispred_d = stat_mispred_q + 1'b1;
        end

        if (flush) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
            rr_ptr_q        <= '0;
            mispredict_q    <= 1'b0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            target_q        <= target_d;
            ctr_q           <= ctr_d;
            rr_ptr_q        <= rr_ptr_d;
            mispredict_q    <= mispredict_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    always_comb begin
        mispredict    = mispredict_q;
        stat_branches = stat_branches_q;
        stat_mispred  = stat_mispred_q;
        dbg_valid     = valid_q[dbg_idx];
        dbg_tag       = tag_q[dbg_idx];
        dbg_target    = target_q[dbg_idx];
        dbg_state     = ctr_q[dbg_idx];
    end

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed self-checking bench for btb_predictor with
// default parameters (8 entries, 2-bit counters, 16-bit statistics).
module tb_btb_predictor;

    logic        clk;
    logic        RST;
    logic        flush;
    logic [31:0] pc_in;
    logic        hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_pred;
    logic        mispredict;
    logic [2:0]  dbg_idx;
    logic        dbg_valid;
    logic [31:0] dbg_tag;
    logic [31:0] dbg_target;
    logic [1:0]  dbg_state;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispred;

    int errors;
    int checks;
    int exp_br;
    int exp_mp;

    btb_predictor #(
        .ENTRIES  (8),
        .CTR_BITS (2),
        .CNT_W    (16)
    ) dut (
        .clk           (clk),
        .RST           (RST),
        .flush         (flush),
        .pc_in         (pc_in),
        .hit           (hit),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken),
        .upd_pred      (upd_pred),
        .mispredict    (mispredict),
        .dbg_idx       (dbg_idx),
        .dbg_valid     (dbg_valid),
        .dbg_tag       (dbg_tag),
        .dbg_target    (dbg_target),
        .dbg_state     (dbg_state),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle resolved-branch update; tracks expected statistics.
    task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic taken, input logic pred);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = taken;
        upd_pred   = pred;
        exp_br++;
        if (taken != pred) exp_mp++;
        tick();
        upd_valid = 1'b0;
        #1;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_br"}, 32'(stat_branches), 32'(exp_br));
        check({tag, "_mp"}, 32'(stat_mispred), 32'(exp_mp));
    endtask

    initial begin
        errors = 0; checks = 0; exp_br = 0; exp_mp = 0;
        RST = 1'b1; flush = 1'b0; pc_in = 32'h40;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
        upd_taken = 1'b0; upd_pred = 1'b0; dbg_idx = '0;

        // Outputs while reset is held
        #1;
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_ptaken", 32'(pred_taken), 32'd0);
        check("rst_ptarget", pred_target, 32'h44);
        tick();
        tick();
        check("rst_dbg_valid", 32'(dbg_valid), 32'd0);
        check("rst_mispred_out", 32'(mispredict), 32'd0);
        check_stats("rst");
        RST = 1'b0;
        #1;

        // Allocate then predict
        do_upd(32'h40, 32'h10, 1'b1, 1'b0);
        pc_in = 32'h40; dbg_idx = 3'd0; #1;
        check("alloc_hit", 32'(hit), 32'd1);
        check("alloc_ptaken", 32'(pred_taken), 32'd1);
        check("alloc_ptarget", pred_target, 32'h10);
        check("alloc_state", 32'(dbg_state), 32'd2);
        check("alloc_tag", dbg_tag, 32'h40);
        check("alloc_mispredict", 32'(mispredict), 32'd1);
        check_stats("alloc");

        // Saturate up
        for (int i = 0; i < 3; i++) do_upd(32'h40, 32'h10, 1'b1, 1'b1);
        check("sat_hi_state", 32'(dbg_state), 32'd3);
        check("sat_hi_mispredict", 32'(mispredict), 32'd0);
        // Down to weakly not-taken
        for (int i = 0; i < 2; i++) do_upd(32'h40, 32'h10, 1'b0, 1'b1);
        check("wnt_state", 32'(dbg_state), 32'd1);
        check("wnt_hit", 32'(hit), 32'd1);
        check("wnt_ptaken", 32'(pred_taken), 32'd0);
        check("wnt_ptarget", pred_target, 32'h44);
        // Saturate down
        for (int i = 0; i < 2; i++) do_upd(32'h40, 32'h10, 1'b0, 1'b0);
        check("sat_lo_state", 32'(dbg_state), 32'd0);
        check_stats("sat");

        // Back to weakly taken; second update rewrites the target
        do_upd(32'h40, 32'h10, 1'b1, 1'b0);
        do_upd(32'h40, 32'h20, 1'b1, 1'b1);
        check("retgt_state", 32'(dbg_state), 32'd2);
        check("retgt_ptarget", pred_target, 32'h20);

        // Collision: lookup sees pre-update state, no bypass
        upd_valid = 1'b1; upd_pc = 32'h40; upd_target = 32'h99;
        upd_taken = 1'b0; upd_pred = 1'b1;
        exp_br++; exp_mp++;
        #1;
        check("coll_ptaken_same", 32'(pred_taken), 32'd1);
        check("coll_ptarget_same", pred_target, 32'h20);
        tick();
        upd_valid = 1'b0; #1;
        check("coll_state_after", 32'(dbg_state), 32'd1);
        check("coll_target_kept", dbg_target, 32'h20);
        check("coll_ptaken_after", 32'(pred_taken), 32'd0);

        // Miss with not-taken allocates nothing
        do_upd(32'h300, 32'h500, 1'b0, 1'b0);
        dbg_idx = 3'd1; pc_in = 32'h300; #1;
        check("nt_miss_valid1", 32'(dbg_valid), 32'd0);
        check("nt_miss_hit", 32'(hit), 32'd0);

        // Flush wins over a same-cycle update; stats still count it
        flush = 1'b1;
        do_upd(32'h80, 32'h88, 1'b0, 1'b1);
        flush = 1'b0;
        dbg_idx = 3'd0; pc_in = 32'h40; #1;
        check("flush_valid0", 32'(dbg_valid), 32'd0);
        check("flush_hit", 32'(hit), 32'd0);
        check("flush_ctr_kept", 32'(dbg_state), 32'd1);
        check("flush_mispredict", 32'(mispredict), 32'd1);
        check_stats("flush");

        // Flush with a taken miss: no allocation
        flush = 1'b1;
        do_upd(32'h80, 32'h88, 1'b1, 1'b1);
        flush = 1'b0;
        pc_in = 32'h80; #1;
        check("flush_noalloc_hit", 32'(hit), 32'd0);

        // Fill all 8 entries, then replace via round-robin
        for (int i = 0; i < 8; i++) do_upd(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1, 1'b1);
        dbg_idx = 3'd7; #1;
        check("fill_tag7", dbg_tag, 32'h11C);
        check("fill_valid7", 32'(dbg_valid), 32'd1);
        do_upd(32'h200, 32'h2000, 1'b1, 1'b0);
        dbg_idx = 3'd0; pc_in = 32'h100; #1;
        check("repl_tag0", dbg_tag, 32'h200);
        check("repl_state0", 32'(dbg_state), 32'd2);
        check("repl_miss_100", 32'(hit), 32'd0);
        pc_in = 32'h104; #1;
        check("repl_hit_104", 32'(hit), 32'd1);
        do_upd(32'h204, 32'h2004, 1'b1, 1'b1);
        dbg_idx = 3'd1; #1;
        check("rr_tag1", dbg_tag, 32'h204);
        check("rr_miss_104", 32'(hit), 32'd0);
        pc_in = 32'h200; #1;
        check("rr_ptarget_200", pred_target, 32'h2000);
        check_stats("repl");

        // Reset mid-run
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_br = 0; exp_mp = 0;
        #1;
        for (int i = 0; i < 8; i++) begin
            dbg_idx = 3'(i);
            #1;
            check($sformatf("mrst_valid%0d", i), 32'(dbg_valid), 32'd0);
        end
        dbg_idx = 3'd0; #1;
        check("mrst_tag0", dbg_tag, 32'h0);
        check("mrst_state0", 32'(dbg_state), 32'd0);
        check_stats("mrst");
        pc_in = 32'h200; #1;
        check("mrst_hit", 32'(hit), 32'd0);
        check("mrst_ptarget", pred_target, 32'h204);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, number of fully-associative BTB entries (power of two, 2..64).
REQ-002 SHALL have parameter CTR_BITS, default 2, width of the per-entry saturating direction counter (1..4).
REQ-003 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous active-high reset.
- flush  in  1  clears all valid bits; counters and statistics are kept.
- pc_in  in  32  IF-stage PC to look up.
- hit  out  1  pc_in matches a valid entry.
- pred_taken  out  1  hit AND counter MSB==1.
- pred_target  out  32  stored target when pred_taken, else pc_in+4.
- upd_valid  in  1  EX-stage branch resolved this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_target  in  32  actual taken target.
- upd_taken  in  1  actual outcome.
- upd_pred  in  1  prediction that was carried down the pipe with the branch.
- mispredict  out  1  registered: upd_valid AND (upd_pred != upd_taken) in the previous cycle.
- dbg_idx  in  log2(ENTRIES)  entry selected for the display port.
- dbg_valid / dbg_tag / dbg_target / dbg_state  out  1/32/32/CTR_BITS  contents of entry dbg_idx.
- stat_branches / stat_mispred  out  CNT_W each  resolved-branch count and mispredict count.

Function
REQ-005 Lookup SHALL be combinational, with zero-cycle latency from pc_in to hit/pred_taken/pred_target.
REQ-006 The tag SHALL be the full 32-bit PC, and at most one entry SHALL match any PC.
REQ-007 On upd_valid with a hit on upd_pc, the counter SHALL increment (saturating at 2^CTR_BITS-1) when upd_taken=1, else decrement (saturating at 0).
REQ-008 On a hit with upd_taken=1, the entry's target SHALL be overwritten with upd_target.
REQ-009 On upd_valid with a miss and upd_taken=1, an entry SHALL be allocated: tag=upd_pc, target=upd_target, counter=2^(CTR_BITS-1) (weakly taken), valid=1.
REQ-010 On a miss with upd_taken=0, no allocation SHALL occur and the BTB SHALL be unchanged.
REQ-011 Victim selection SHALL be the lowest-index invalid entry if one exists, else the entry at the round-robin pointer rr_ptr.
REQ-012 rr_ptr SHALL advance by 1 (mod ENTRIES) only when it was used as the victim.
REQ-013 When update and lookup hit the same PC in the same cycle, lookup SHALL return the pre-update state (no bypass).
REQ-014 When flush and upd_valid occur in the same cycle, flush SHALL win: all valid bits are 0 next cycle, no allocation happens, and statistics still count the update.
REQ-015 stat_branches SHALL increment on every upd_valid; stat_mispred SHALL increment when upd_valid AND upd_pred!=upd_taken; both saturate at 2^CNT_W-1.
REQ-016 The debug port SHALL be combinational, reflect registered state only, and never alter state.

Reset
REQ-017 On RST, the following SHALL clear on the next edge: all valid=0, tags=0, targets=0, counters=0, rr_ptr=0, mispredict=0, both statistics counters=0.
REQ-018 RST SHALL take priority over flush and upd_valid.
REQ-019 While RST is held, hit and pred_taken SHALL be 0 and pred_target SHALL be pc_in+4.

Verification
REQ-020 Allocate then predict: update pc=0x0000_0040 taken, target 0x0000_0010 -> next cycle, lookup 0x40 gives hit=1, pred_taken=1, pred_target=0x10, dbg_state=2'b10.
REQ-021 Saturation, with that entry: 3 taken updates -> state 2'b11; then 2 not-taken -> 2'b01 and pred_taken=0 with pred_target=0x44; 2 more not-taken -> state stays 2'b00.
REQ-022 Replacement with ENTRIES=8: fill 8 taken branches at 0x100..0x11C, then a 9th at 0x200 -> it replaces entry 0, rr_ptr=1, and lookup 0x100 misses.
REQ-023 Collision: a lookup of 0x40 and a not-taken update of 0x40 (state 2'b10) in the same cycle -> pred_taken=1 that cycle, state 2'b01 after.
REQ-024 Flush and statistics: upd_valid with upd_pred=1, upd_taken=0 together with flush -> all valid=0, stat_branches+1, stat_mispred+1, mispredict=1 next cycle.
REQ-025 Reset mid-run: assert RST for 1 cycle after REQ-022 -> every dbg_valid=0, both statistics counters=0, and lookup 0x200 gives hit=0 with pred_target=0x204.
